// File: rtl/dmem_responder_pkg.sv
// Shared types and defaults for the data-memory responder and its storage array.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam int DEF_ADDR_W      = 10;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_DEPTH       = 1024;
    localparam int DEF_WAIT_CYCLES = 2;
    localparam int BYTE_W          = 8;
    localparam int DEF_LANES       = DEF_DATA_W / BYTE_W;

    // Number of byte lanes in a data word of the given width.
    function automatic int lanes_of(input int data_w);
        return data_w / BYTE_W;
    endfunction

endpackage

// File: rtl/dmem_bytelane_ram.sv
// Synchronous word array with per-byte write enables and a registered read port.
// Contents are never cleared; a read updates rdata only on an enabled read cycle.
module dmem_bytelane_ram
    import dmem_responder_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = DEF_LANES,
    parameter int AW     = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [LANES-1:0]  be,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // One access per enabled cycle: byte-masked write, or read into the output register.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < LANES; i++) begin
                    if (be[i]) begin
                        mem_q[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the data-memory port: one request at a time, a fixed
// number of wait states, a word read or byte-masked write, then a held response.
// Optional macro DMEM_RESP_BACK2BACK_EN lets a new request be accepted in the same
// cycle the previous response is taken, removing the idle cycle between accesses.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int LANES  = lanes_of(DATA_W);
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);
    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rd_sel_q, rd_sel_d;
    logic [31:0]       acc_cnt_q, acc_cnt_d;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [LANES-1:0]  be_q, be_d;

    logic              req_fire;
    logic              rsp_fire;
    logic              in_range;
    logic              ram_en;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

`ifdef DMEM_RESP_BACK2BACK_EN
    // While a response is waiting, readiness for the next request follows the
    // requester's readiness for the response, so both handshakes can share a cycle.
    assign req_ready = req_ready_q | ((state_q == ST_RESP) & rsp_ready & ~reset);
`else
    assign req_ready = req_ready_q;
`endif

    assign req_fire  = req_valid & req_ready;
    assign rsp_fire  = rsp_valid_q & rsp_ready;
    assign in_range  = ({1'b0, addr_q} < DEPTH_L);

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    // Read data is only exposed for an in-range read; writes and errors show zero.
    assign rsp_rdata = rd_sel_q ? ram_rdata : '0;

    // Next-state, request latching and array-access control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rd_sel_d    = rd_sel_q;
        acc_cnt_d   = acc_cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        ram_en      = 1'b0;
        ram_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
            end
            ST_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_ACCESS;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACCESS: begin
                ram_en      = in_range;
                ram_we      = we_q;
                rd_sel_d    = in_range & ~we_q;
                rsp_err_d   = ~in_range;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_fire) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rd_sel_d    = 1'b0;
                    acc_cnt_d   = acc_cnt_q + 32'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A request can only fire in IDLE, or in RESP alongside the response
        // handshake when back-to-back operation is built in.
        if (req_fire) begin
            we_d    = req_we;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            be_d    = req_be;
            cnt_d   = WAIT_LD;
            state_d = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
        end

        req_ready_d = (state_d == ST_IDLE);
    end

    // State register; control is reset, the latched request fields are not.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_sel_q    <= 1'b0;
            acc_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rd_sel_q    <= rd_sel_d;
            acc_cnt_q   <= acc_cnt_d;
        end
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
    end

    // Reset blocks the access so an in-flight write is never committed.
    dmem_bytelane_ram #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .AW     (RAM_AW),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en & ~reset),
        .we    (ram_we),
        .be    (be_q),
        .addr  (addr_q[RAM_AW-1:0]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, backpressure, reset mid-access,
// streaming throughput, and randomized traffic against a word/byte-mask memory model.
module tb_dmem_responder;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1024;
    localparam int W      = 2;
    localparam int LAT    = 2 + W;
`ifdef DMEM_RESP_BACK2BACK_EN
    localparam int PERIOD = 2 + W;
`else
    localparam int PERIOD = 3 + W;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    int n_cmp = 0;
    int n_bad = 0;
    int hs    = 0;

    logic [31:0] mdata  [int];
    logic [3:0]  mknown [int];

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: handshake never happened within the cycle budget (expected it to)", name);
    endtask

    // Memory model: words with per-byte knowledge of what the bench has written.
    function automatic void model_write(input int a, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] t;
        logic [3:0]  k;
        if (a >= DEPTH) return;
        t = mdata.exists(a) ? mdata[a] : 32'h0;
        k = mknown.exists(a) ? mknown[a] : 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                t[8*i +: 8] = wd[8*i +: 8];
                k[i] = 1'b1;
            end
        end
        mdata[a]  = t;
        mknown[a] = k;
    endfunction

    function automatic void model_read(input int a, output logic [31:0] e,
                                       output logic [31:0] m, output logic err);
        err = (a >= DEPTH);
        e = 32'h0;
        m = 32'hFFFF_FFFF;
        if (!err) begin
            if (mdata.exists(a)) begin
                e = mdata[a];
                for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{mknown[a][i]}};
            end else begin
                m = 32'h0;
            end
        end
    endfunction

    // One complete request/response; called and returns on a negative clock edge.
    task automatic txn(input logic we, input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input int bp,
                       output logic [31:0] rd, output logic err, output int lat, output bit ok);
        int t;
        ok = 1'b1; rd = '0; err = 1'b0; lat = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
        rsp_ready = (bp == 0);
        t = 0;
        while (req_ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) begin timeout_fail("accept"); ok = 1'b0; req_valid = 1'b0; return; end
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = ADDR_W'($urandom);
        req_wdata = $urandom; req_be = 4'($urandom);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        if (lat >= 40) begin timeout_fail("response"); ok = 1'b0; rsp_ready = 1'b1; return; end
        rd = rsp_rdata; err = rsp_err;
        repeat (bp) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        hs++;
    endtask

    task automatic do_and_check(input string tag, input logic we, input logic [ADDR_W-1:0] a,
                                input logic [31:0] wd, input logic [3:0] be, input int bp);
        logic [31:0] e, m, rd;
        logic        ee, err;
        int          lat;
        bit          ok;
        model_read(int'(a), e, m, ee);
        if (we) begin e = '0; m = '1; end
        txn(we, a, wd, be, bp, rd, err, lat, ok);
        if (ok) begin
            check({tag, "_lat"}, 64'(lat), 64'(LAT));
            check({tag, "_err"}, 64'(err), 64'(ee));
            check({tag, "_rdata"}, 64'(rd & m), 64'(e & m));
            if (we) model_write(int'(a), wd, be);
        end
    endtask

    // Four reads streamed with rsp_ready high; checks per-access latency and accept spacing.
    task automatic stream_test();
        logic [ADDR_W-1:0] sa [4];
        int acc_e [4];
        int rsp_e [4];
        int na, nr;
        bit fa, fr;
        logic [31:0] e, m;
        logic ee;
        sa[0] = 11'd5; sa[1] = 11'd7; sa[2] = 11'd0; sa[3] = 11'd1023;
        na = 0; nr = 0;
        req_we = 1'b0; req_be = 4'h0; req_wdata = 32'h0; req_addr = sa[0];
        req_valid = 1'b1; rsp_ready = 1'b1;
        for (int c = 0; c < 80 && nr < 4; c++) begin
            fa = req_valid && req_ready;
            fr = rsp_valid && rsp_ready;
            if (fr) begin
                model_read(int'(sa[nr]), e, m, ee);
                check("stream_rdata", 64'(rsp_rdata & m), 64'(e & m));
                rsp_e[nr] = c;
                nr++;
            end
            if (fa) begin acc_e[na] = c; na++; end
            @(posedge clk); #1;
            if (fa) begin
                if (na == 4) req_valid = 1'b0;
                else req_addr = sa[na];
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        if (nr < 4) timeout_fail("stream");
        hs += nr;
        for (int i = 0; i < nr; i++) check("stream_lat", 64'(rsp_e[i] - acc_e[i]), 64'(LAT));
        for (int i = 1; i < na; i++) check("stream_period", 64'(acc_e[i] - acc_e[i-1]), 64'(PERIOD));
    endtask

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [3:0]        be;
        logic [31:0]       exp_rd;
        logic              exp_err;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time limit (expected to finish)");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [12];
        logic [31:0] rd, cnt0;
        logic        err;
        int          lat, bad_cyc;
        bit          ok;

        tbl[0]  = '{1'b1, 11'd5,    32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 11'd5,    32'hFFFFFFFF, 4'hF, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 11'd7,    32'h11223344, 4'hF, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 11'd7,    32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 11'd7,    32'h0,        4'h0, 32'h11BB33DD, 1'b0};
        tbl[5]  = '{1'b1, 11'd0,    32'h12345678, 4'hF, 32'h0,        1'b0};
        tbl[6]  = '{1'b1, 11'd1023, 32'h0F0F0F0F, 4'hF, 32'h0,        1'b0};
        tbl[7]  = '{1'b0, 11'd1023, 32'h0,        4'h0, 32'h0F0F0F0F, 1'b0};
        tbl[8]  = '{1'b0, 11'd1024, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        tbl[9]  = '{1'b1, 11'd1024, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        tbl[10] = '{1'b0, 11'd0,    32'h0,        4'h0, 32'h12345678, 1'b0};
        tbl[11] = '{1'b0, 11'd2047, 32'h0,        4'h0, 32'h0,        1'b1};

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_be = '0; rsp_ready = 1'b0;

        // Reset values
        @(negedge clk); @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        check("rst_rsp_err",   64'(rsp_err),   64'(0));
        reset = 1'b0;
        @(negedge clk);
        check("rst_release_req_ready", 64'(req_ready), 64'(1));

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, 0, rd, err, lat, ok);
            if (ok) begin
                check($sformatf("vec%0d_lat", i),   64'(lat), 64'(LAT));
                check($sformatf("vec%0d_err", i),   64'(err), 64'(tbl[i].exp_err));
                check($sformatf("vec%0d_rdata", i), 64'(rd),  64'(tbl[i].exp_rd));
            end
            if (tbl[i].we) model_write(int'(tbl[i].addr), tbl[i].wdata, tbl[i].be);
        end

        // Backpressure: response held 10 cycles while a competing request waits
        check("bp_idle_req_ready", 64'(req_ready), 64'(1));
        req_valid = 1'b1; req_we = 1'b0; req_addr = 11'd5; req_wdata = '0; req_be = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_we = 1'b1; req_wdata = 32'h0; req_be = 4'hF;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        if (lat >= 40) timeout_fail("bp_response");
        check("bp_lat", 64'(lat), 64'(LAT));
        for (int i = 0; i < 10; i++) begin
            check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
            check("bp_rdata",     64'(rsp_rdata), 64'(32'hDEADBEEF));
            check("bp_req_ready", 64'(req_ready), 64'(0));
            @(negedge clk);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        hs++;
        check("bp_done_rsp_valid", 64'(rsp_valid), 64'(0));
        check("bp_done_req_ready", 64'(req_ready), 64'(1));
        do_and_check("bp_after_read", 1'b0, 11'd5, 32'h0, 4'h0, 0);

        // Reset during WAIT drops an in-flight write
        do_and_check("pre_write3", 1'b1, 11'd3, 32'h01020304, 4'hF, 0);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 11'd3; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
        rsp_ready = 1'b1;
        check("mid_rst_accept_ready", 64'(req_ready), 64'(1));
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("mid_rst_req_ready", 64'(req_ready), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_release_req_ready", 64'(req_ready), 64'(1));
        bad_cyc = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid !== 1'b0) bad_cyc++;
            @(negedge clk);
        end
        check("mid_rst_no_response_cycles", 64'(bad_cyc), 64'(0));
        cnt0 = dut.acc_cnt_q;
        hs = 0;
        do_and_check("mid_rst_read3", 1'b0, 11'd3, 32'h0, 4'h0, 0);

        // Streaming reads
        stream_test();

        // Randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            logic              we;
            logic [ADDR_W-1:0] a;
            int                bp;
            we = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 9) < 7) ? ADDR_W'($urandom_range(0, 15))
                                            : ADDR_W'($urandom_range(1018, 1030));
            bp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            do_and_check("rand", we, a, $urandom, 4'($urandom), bp);
        end

        check("acc_counter", 64'(dut.acc_cnt_q - cnt0), 64'(hs));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
